// File: rtl/rgb_led_pkg.sv
// Shared types and colour constants for the RGB LED driver and its command sources.
package rgb_led_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_FADE_IN  = 2'd2
  } state_t;

  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_WHITE = 3'b111;

endpackage

// File: rtl/rgb_led_driver_if.sv
// Colour/brightness command channel: valid/ready handshake from a sequencer to the driver.
interface rgb_led_driver_if #(
  parameter int LEVEL_W = 4
);
  logic [2:0]         cmd_rgb;
  logic [LEVEL_W-1:0] cmd_level;
  logic               cmd_valid;
  logic               cmd_ready;

  modport master (output cmd_rgb, output cmd_level, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_rgb, input cmd_level, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/rgb_led_driver_pwm_timebase.sv
// Prescaled PWM counter; period_end marks the last clock of each PWM period.
module pwm_timebase #(
  parameter int LEVEL_W  = 4,
  parameter int PRESCALE = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [LEVEL_W-1:0] pwm_cnt,
  output logic               tick,
  output logic               period_end
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSC_W-1:0] psc;

  assign tick       = (psc == PSC_W'(PRESCALE - 1));
  assign period_end = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc     <= '0;
      pwm_cnt <= '0;
    end else begin
      psc <= tick ? '0 : psc + PSC_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + LEVEL_W'(1);
    end
  end

endmodule

// File: rtl/rgb_led_driver.sv
// PWM RGB LED driver: accepts colour/level commands and fades old colour out, new colour in.
module rgb_led_driver
  import rgb_led_pkg::*;
#(
  parameter int LEVEL_W           = 4,
  parameter int PRESCALE          = 16,
  parameter int FADE_STEP_PERIODS = 2
) (
  input  logic             clk,
  input  logic             rst,
  rgb_led_driver_if.slave  cmd,
  output logic [2:0]       led_rgb,
  output logic             busy
);

  localparam int STEP_W = (FADE_STEP_PERIODS > 1) ? $clog2(FADE_STEP_PERIODS) : 1;

  state_t             state, state_nxt;
  logic [2:0]         cur_rgb, pend_rgb;
  logic [LEVEL_W-1:0] cur_level, pend_level, pwm_cnt;
  logic [STEP_W-1:0]  step_cnt;
  logic               tick, period_end, ready, accept, step;

  pwm_timebase #(.LEVEL_W(LEVEL_W), .PRESCALE(PRESCALE)) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .pwm_cnt    (pwm_cnt),
    .tick       (tick),
    .period_end (period_end)
  );

  assign ready         = (state == S_IDLE);
  assign cmd.cmd_ready = ready;
  assign busy          = !ready;
  assign accept        = cmd.cmd_valid && ready;
  assign step          = period_end && (step_cnt == STEP_W'(FADE_STEP_PERIODS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (accept)
          state_nxt = (cmd.cmd_rgb == cur_rgb || cur_level == '0) ? S_FADE_IN : S_FADE_OUT;
      S_FADE_OUT:
        if (cur_level == '0 || (step && cur_level == LEVEL_W'(1))) state_nxt = S_FADE_IN;
      // Leave only once the colour swap has landed too, so a dark start with level 0 still updates cur_rgb.
      S_FADE_IN:
        if (cur_level == pend_level && cur_rgb == pend_rgb) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Fade datapath: every change lands on a period boundary so a PWM period is never cut short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_rgb    <= RGB_OFF;
      cur_level  <= '0;
      pend_rgb   <= RGB_OFF;
      pend_level <= '0;
      step_cnt   <= '0;
    end else if (accept) begin
      pend_rgb   <= cmd.cmd_rgb;
      pend_level <= cmd.cmd_level;
      step_cnt   <= '0;
    end else if (tick && period_end && state != S_IDLE) begin
      step_cnt <= step ? '0 : step_cnt + STEP_W'(1);
      if (state == S_FADE_OUT) begin
        if (step && cur_level != '0) begin
          cur_level <= cur_level - LEVEL_W'(1);
          if (cur_level == LEVEL_W'(1)) cur_rgb <= pend_rgb;
        end
      end else if (state == S_FADE_IN) begin
        cur_rgb <= pend_rgb;
        if (step && cur_level < pend_level)      cur_level <= cur_level + LEVEL_W'(1);
        else if (step && cur_level > pend_level) cur_level <= cur_level - LEVEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_rgb <= 3'b000;
    else      led_rgb <= cur_rgb & {3{pwm_cnt < cur_level}};
  end

endmodule

// File: doc/rgb_led_driver.md
Name: rgb_led_driver

Overview:
- Consumer end of the RGB colour interface. It accepts colour and brightness commands from a sequencer or controller over a valid/ready handshake.
- Drives the three LED pins with PWM.
- Colour changes are smoothed: fade the old colour to dark, swap colour, fade up to the new level.
- Sits between FSM-level logic (sequencers, button-driven controllers) and the board LED pins.

Parameters:
- LEVEL_W, 4: brightness width. PWM period is 2**LEVEL_W counts.
- PRESCALE, 16: clocks per PWM count. Must be at least 1.
- FADE_STEP_PERIODS, 2: PWM periods per one-unit brightness step during a fade. Must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_rgb  in  3  requested colour bits {r,g,b}
- cmd_level  in  LEVEL_W  requested brightness; 0 means off
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command; equals (state==S_IDLE)
- led_rgb  out  3  registered PWM outputs {r,g,b}
- busy  out  1  fade in progress; equals !cmd_ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE; cur_rgb=0, cur_level=0, pend_rgb=0, pend_level=0.
  - Prescaler, pwm_cnt and step counter cleared; led_rgb=3'b000.
  - cmd_valid is ignored while rst=0.
- Timebase:
  - Prescaler counts 0..PRESCALE-1. tick pulses when it wraps.
  - pwm_cnt increments on tick and wraps (2**LEVEL_W)-1 to 0.
  - period_end = tick && pwm_cnt==max.
- PWM:
  - Next-cycle led_rgb[i] = cur_rgb[i] && (pwm_cnt < cur_level). Duty is cur_level/2**LEVEL_W, so maximum duty is 15/16 at LEVEL_W=4. One clock of output latency.
  - cur_level and cur_rgb change only on period_end cycles, so no mid-period glitches.
- Handshake:
  - Accept when cmd_valid && cmd_ready. Latch pend_rgb and pend_level; clear the step counter.
  - cmd_ready is low for every non-idle state. No queueing: a cmd_valid held during busy waits, and its payload must stay stable.
- FSM (shared enum):
  - S_IDLE: on accept, if cmd_rgb==cur_rgb or cur_level==0, go to S_FADE_IN. A dark or same-colour channel needs no fade-out. In the cur_level==0 case, cur_rgb loads pend_rgb on the next period_end. Otherwise go to S_FADE_OUT.
  - S_FADE_OUT: on each step (every FADE_STEP_PERIODS period_ends), cur_level -= 1. On the step where cur_level reaches 0, cur_rgb <= pend_rgb and go to S_FADE_IN.
  - S_FADE_IN: on each step, move cur_level one unit toward pend_level, up or down. When cur_level==pend_level, go to S_IDLE on the same cycle; zero steps is allowed. pend_level=0 with a new colour therefore ends dark, with cur_rgb updated.
  - No other states; unreachable encodings go to S_IDLE.
- Arithmetic: all level math is unsigned LEVEL_W bits. It never wraps, because decrement is guarded at 0 and increment at pend_level.
- Reset mid-fade: immediate dark, S_IDLE, all pending data lost.
- A command arriving on the same cycle as period_end is accepted. Its first step happens FADE_STEP_PERIODS full period_ends later.

Decomposition:
- Package rgb_led_pkg holds:
  - state_t enum {S_IDLE, S_FADE_OUT, S_FADE_IN}, logic[1:0].
  - Colour constants RGB_OFF=3'b000, RGB_RED=3'b100, RGB_GREEN=3'b010, RGB_BLUE=3'b001, RGB_WHITE=3'b111.
- One sub-module, pwm_timebase, parameterised by LEVEL_W and PRESCALE. Outputs pwm_cnt, tick and period_end.

Test Plan (LEVEL_W=4, PRESCALE=2, FADE_STEP_PERIODS=1, so period = 32 clocks):
1. Reset: hold rst=0 with cmd_valid=1 -> led_rgb=000, cmd_ready=1, no accept. Release -> still dark.
2. Idle-to-red: from dark, send RGB_RED with level 8 -> S_FADE_IN. cur_level reaches 8 after 8 period_ends, then cmd_ready=1. In steady state led_rgb[2] is high 16 of every 32 clocks, and bits [1:0] stay 0.
3. Colour change: red@15 then green@4 -> red ramps down 15 steps to 0. Green rises over 4 steps. Total busy is about 19 periods (±1), and red and green are never high together.
4. Same colour, lower level: red@12 then red@3 -> no fade-out. Red ramps down 9 steps, ends at 6/32 duty per period.
5. Level 0 with new colour: blue@5 then white@0 -> fade out 5 steps, cur_rgb=111, cmd_ready=1, led_rgb stays 000.
6. Reset mid-fade and backpressure: assert rst during S_FADE_OUT -> led_rgb=000 asynchronously. Separately, hold a second cmd_valid during a fade -> not accepted until cmd_ready=1, then accepted exactly once.
